// File: rtl/axis_dwidth_conv_n_pkg.sv
// Shared constants and helpers for the AXI4-Stream width converters.
package axis_dwidth_conv_n_pkg;

  localparam int AXIS_DWIDTH_MAX_RATIO = 8;

  // Counter width for a lane/segment ratio; never below 1 so the counter stays declarable.
  function automatic int clog2_ratio(input int ratio);
    int w;
    w = 0;
    while ((1 << w) < ratio) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_dwidth_slice.sv
// One-beat AXI4-Stream output register; payload holds while stalled.
module axis_dwidth_slice #(
  parameter int DATA_BITS = 256,
  parameter int ID_BITS   = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_BITS-1:0]   s_data,
  input  logic [DATA_BITS/8-1:0] s_keep,
  input  logic [ID_BITS-1:0]     s_id,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_BITS-1:0]   m_data,
  output logic [DATA_BITS/8-1:0] m_keep,
  output logic [ID_BITS-1:0]     m_id,
  output logic                   m_last
);

  assign s_ready = !m_valid || m_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_id    <= '0;
      m_last  <= 1'b0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) begin
        m_data <= s_data;
        m_keep <= s_keep;
        m_id   <= s_id;
        m_last <= s_last;
      end
    end
  end

endmodule

// File: rtl/axis_dwidth_conv_n.sv
// AXI4-Stream width converter: downsize, upsize or register slice, chosen by the width ratio.
module axis_dwidth_conv_n
  import axis_dwidth_conv_n_pkg::*;
#(
  parameter int S_DATA_BITS = 512,
  parameter int M_DATA_BITS = 256,
  parameter int ID_BITS     = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [S_DATA_BITS-1:0]   s_axis_tdata,
  input  logic [S_DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic [ID_BITS-1:0]       s_axis_tid,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [M_DATA_BITS-1:0]   m_axis_tdata,
  output logic [M_DATA_BITS/8-1:0] m_axis_tkeep,
  output logic [ID_BITS-1:0]       m_axis_tid,
  output logic                     m_axis_tlast
);

  localparam int S_KEEP = S_DATA_BITS / 8;
  localparam int M_KEEP = M_DATA_BITS / 8;
  localparam int BIG    = (S_DATA_BITS > M_DATA_BITS) ? S_DATA_BITS : M_DATA_BITS;
  localparam int SMALL  = (S_DATA_BITS > M_DATA_BITS) ? M_DATA_BITS : S_DATA_BITS;
  localparam int RATIO  = BIG / SMALL;

  if ((S_DATA_BITS % 8 != 0) || (M_DATA_BITS % 8 != 0) || (BIG % SMALL != 0) ||
      (RATIO > AXIS_DWIDTH_MAX_RATIO) || ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_ratio
    $error("axis_dwidth_conv_n: widths must be byte multiples with ratio 1, 2, 4 or 8");
  end

  // Holds s_axis_tready low through reset and until the first clock after release.
  logic ready_en;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  logic                   sl_valid, sl_ready, sl_last;
  logic [M_DATA_BITS-1:0] sl_data;
  logic [M_KEEP-1:0]      sl_keep;
  logic [ID_BITS-1:0]     sl_id;

  axis_dwidth_slice #(.DATA_BITS(M_DATA_BITS), .ID_BITS(ID_BITS)) u_slice (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(sl_valid), .s_ready(sl_ready),
    .s_data(sl_data), .s_keep(sl_keep), .s_id(sl_id), .s_last(sl_last),
    .m_valid(m_axis_tvalid), .m_ready(m_axis_tready),
    .m_data(m_axis_tdata), .m_keep(m_axis_tkeep), .m_id(m_axis_tid), .m_last(m_axis_tlast)
  );

  if (S_DATA_BITS == M_DATA_BITS) begin : g_pass
    assign s_axis_tready = ready_en && sl_ready;
    assign sl_valid      = s_axis_tvalid && s_axis_tready;
    assign sl_data       = s_axis_tdata;
    assign sl_keep       = s_axis_tkeep;
    assign sl_id         = s_axis_tid;
    assign sl_last       = s_axis_tlast;

  end else if (S_DATA_BITS > M_DATA_BITS) begin : g_down
    localparam int SEG_W = clog2_ratio(RATIO);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t                              state, state_nxt;
    logic [SEG_W-1:0]                    seg, seg_nx;
    logic [RATIO-1:0][M_DATA_BITS-1:0]   buf_data;
    logic [RATIO-1:0][M_KEEP-1:0]        buf_keep, s_keep_seg;
    logic [ID_BITS-1:0]                  buf_id;
    logic                                buf_last;
    logic [RATIO-1:0]                    buf_upper_empty;
    logic                                s_upper_empty, seg_last, s_fire, adv;

    assign s_keep_seg    = s_axis_tkeep;
    assign s_upper_empty = ~|s_keep_seg[RATIO-1:1];
    assign seg_nx        = seg + 1'b1;

    // buf_upper_empty[k]: no byte of the latched beat is enabled above segment k.
    for (genvar k = 0; k < RATIO; k++) begin : g_upper
      if (k == RATIO - 1) begin : g_top
        assign buf_upper_empty[k] = 1'b1;
      end else begin : g_mid
        assign buf_upper_empty[k] = ~|buf_keep[RATIO-1:k+1];
      end
    end

    assign seg_last = (seg == SEG_W'(RATIO - 1)) || (buf_last && buf_upper_empty[seg]);

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
    end

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (s_fire) state_nxt = EMIT;
        EMIT:    if (m_axis_tready && seg_last && !s_fire) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Segment 0 of a fresh beat goes straight into the slice; later segments come from the buffer.
    always_comb begin
      s_axis_tready = ready_en && ((state == IDLE) || (m_axis_tready && seg_last));
      s_fire        = s_axis_tvalid && s_axis_tready;
      adv           = (state == EMIT) && m_axis_tready && !seg_last;
      sl_valid      = s_fire || adv;
      if (s_fire) begin
        sl_data = s_axis_tdata[M_DATA_BITS-1:0];
        sl_keep = s_keep_seg[0];
        sl_id   = s_axis_tid;
        sl_last = s_axis_tlast && s_upper_empty;
      end else begin
        sl_data = buf_data[seg_nx];
        sl_keep = buf_keep[seg_nx];
        sl_id   = buf_id;
        sl_last = buf_last && buf_upper_empty[seg_nx];
      end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        seg      <= '0;
        buf_data <= '0;
        buf_keep <= '0;
        buf_id   <= '0;
        buf_last <= 1'b0;
      end else if (s_fire) begin
        seg      <= '0;
        buf_data <= s_axis_tdata;
        buf_keep <= s_axis_tkeep;
        buf_id   <= s_axis_tid;
        buf_last <= s_axis_tlast;
      end else if (adv) begin
        seg <= seg_nx;
      end
    end

  end else begin : g_up
    localparam int IDX_W = clog2_ratio(RATIO);

    logic [IDX_W-1:0]                  idx;
    logic [RATIO-1:0][S_DATA_BITS-1:0] acc_data, nxt_data;
    logic [RATIO-1:0][S_KEEP-1:0]      acc_keep, nxt_keep;
    logic [ID_BITS-1:0]                acc_id, nxt_id;
    logic                              done, s_fire;

    assign done          = (idx == IDX_W'(RATIO - 1)) || s_axis_tlast;
    assign s_axis_tready = ready_en && (sl_ready || !done);
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    // Unwritten lanes stay zero because the accumulator is cleared on every emit.
    always_comb begin
      nxt_data      = acc_data;
      nxt_keep      = acc_keep;
      nxt_data[idx] = s_axis_tdata;
      nxt_keep[idx] = s_axis_tkeep;
      nxt_id        = (idx == '0) ? s_axis_tid : acc_id;
    end

    assign sl_valid = s_fire && done;
    assign sl_data  = nxt_data;
    assign sl_keep  = nxt_keep;
    assign sl_id    = nxt_id;
    assign sl_last  = s_axis_tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        idx      <= '0;
        acc_data <= '0;
        acc_keep <= '0;
        acc_id   <= '0;
      end else if (s_fire) begin
        if (done) begin
          idx      <= '0;
          acc_data <= '0;
          acc_keep <= '0;
        end else begin
          idx      <= idx + 1'b1;
          acc_data <= nxt_data;
          acc_keep <= nxt_keep;
          acc_id   <= nxt_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_dwidth_conv_n.sv
// Directed bench for the width converter: 512->256, 256->512 and 256->256 instances.
module tb_axis_dwidth_conv_n;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // downsize 512->256
  logic d_s_valid, d_s_ready, d_s_last, d_m_valid, d_m_ready, d_m_last;
  logic [511:0] d_s_data;
  logic [63:0]  d_s_keep;
  logic [255:0] d_m_data;
  logic [31:0]  d_m_keep;
  logic [15:0]  d_s_id, d_m_id;
  // upsize 256->512
  logic u_s_valid, u_s_ready, u_s_last, u_m_valid, u_m_ready, u_m_last;
  logic [255:0] u_s_data;
  logic [31:0]  u_s_keep;
  logic [511:0] u_m_data;
  logic [63:0]  u_m_keep;
  logic [15:0]  u_s_id, u_m_id;
  // pass 256->256
  logic p_s_valid, p_s_ready, p_s_last, p_m_valid, p_m_ready, p_m_last;
  logic [255:0] p_s_data, p_m_data;
  logic [31:0]  p_s_keep, p_m_keep;
  logic [15:0]  p_s_id, p_m_id;

  axis_dwidth_conv_n #(.S_DATA_BITS(512), .M_DATA_BITS(256), .ID_BITS(16)) u_down (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(d_s_valid), .s_axis_tready(d_s_ready), .s_axis_tdata(d_s_data),
    .s_axis_tkeep(d_s_keep), .s_axis_tid(d_s_id), .s_axis_tlast(d_s_last),
    .m_axis_tvalid(d_m_valid), .m_axis_tready(d_m_ready), .m_axis_tdata(d_m_data),
    .m_axis_tkeep(d_m_keep), .m_axis_tid(d_m_id), .m_axis_tlast(d_m_last));

  axis_dwidth_conv_n #(.S_DATA_BITS(256), .M_DATA_BITS(512), .ID_BITS(16)) u_up (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(u_s_valid), .s_axis_tready(u_s_ready), .s_axis_tdata(u_s_data),
    .s_axis_tkeep(u_s_keep), .s_axis_tid(u_s_id), .s_axis_tlast(u_s_last),
    .m_axis_tvalid(u_m_valid), .m_axis_tready(u_m_ready), .m_axis_tdata(u_m_data),
    .m_axis_tkeep(u_m_keep), .m_axis_tid(u_m_id), .m_axis_tlast(u_m_last));

  axis_dwidth_conv_n #(.S_DATA_BITS(256), .M_DATA_BITS(256), .ID_BITS(16)) u_pass (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(p_s_valid), .s_axis_tready(p_s_ready), .s_axis_tdata(p_s_data),
    .s_axis_tkeep(p_s_keep), .s_axis_tid(p_s_id), .s_axis_tlast(p_s_last),
    .m_axis_tvalid(p_m_valid), .m_axis_tready(p_m_ready), .m_axis_tdata(p_m_data),
    .m_axis_tkeep(p_m_keep), .m_axis_tid(p_m_id), .m_axis_tlast(p_m_last));

  function automatic logic [255:0] w(input int k);
    return {8{k}};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    d_s_valid = 0; d_s_data = '0; d_s_keep = '0; d_s_id = '0; d_s_last = 0; d_m_ready = 0;
    u_s_valid = 0; u_s_data = '0; u_s_keep = '0; u_s_id = '0; u_s_last = 0; u_m_ready = 0;
    p_s_valid = 0; p_s_data = '0; p_s_keep = '0; p_s_id = '0; p_s_last = 0; p_m_ready = 0;
    aresetn = 0;
    repeat (3) tick();
    checks++;
    if ({d_m_valid, u_m_valid, p_m_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_mvalid: got %b want 000", {d_m_valid, u_m_valid, p_m_valid});
    end
    checks++;
    if ({d_s_ready, u_s_ready, p_s_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_sready: got %b want 000", {d_s_ready, u_s_ready, p_s_ready});
    end
    checks++;
    if ({d_m_data, d_m_keep, d_m_id, d_m_last} !== '0 || u_m_data !== '0) begin
      errors++; $display("FAIL reset_payload: down %h up %h want 0", d_m_data, u_m_data);
    end
    @(negedge aclk);
    aresetn = 1;
    #1;
    checks++;
    if (d_s_ready !== 1'b0) begin
      errors++; $display("FAIL release_sready_early: got %b want 0", d_s_ready);
    end
    tick();
    checks++;
    if ({d_s_ready, u_s_ready, p_s_ready} !== 3'b111) begin
      errors++; $display("FAIL release_sready: got %b want 111", {d_s_ready, u_s_ready, p_s_ready});
    end
  endtask

  task automatic test_down_full();
    logic [255:0] a, b;
    a = {8{32'hAAAA_0001}};
    b = {8{32'hBBBB_0002}};
    d_m_ready = 0;
    d_s_valid = 1; d_s_data = {a, b}; d_s_keep = '1; d_s_id = 16'h0042; d_s_last = 1;
    tick();
    d_s_valid = 0;
    checks++;
    if ({d_m_valid, d_m_data, d_m_keep, d_m_last} !== {1'b1, b, 32'hFFFF_FFFF, 1'b0}) begin
      errors++; $display("FAIL down_full_seg0: v=%b d=%h k=%h l=%b want v=1 d=%h k=ffffffff l=0",
                         d_m_valid, d_m_data, d_m_keep, d_m_last, b);
    end
    checks++;
    if (d_s_ready !== 1'b0) begin
      errors++; $display("FAIL down_full_busy_ready: got %b want 0", d_s_ready);
    end
    d_m_ready = 1;
    tick();
    checks++;
    if ({d_m_valid, d_m_data, d_m_last, d_m_id} !== {1'b1, a, 1'b1, 16'h0042}) begin
      errors++; $display("FAIL down_full_seg1: v=%b d=%h l=%b id=%h want v=1 d=%h l=1 id=0042",
                         d_m_valid, d_m_data, d_m_last, d_m_id, a);
    end
    tick();
    checks++;
    if (d_m_valid !== 1'b0) begin
      errors++; $display("FAIL down_full_drain: got valid %b want 0", d_m_valid);
    end
  endtask

  task automatic test_down_tail();
    logic [255:0] a, b;
    a = {8{32'hDEAD_0003}};
    b = {8{32'hBEEF_0004}};
    d_m_ready = 1;
    d_s_valid = 1; d_s_data = {a, b}; d_s_keep = 64'h0000_0000_FFFF_FFFF; d_s_last = 1;
    tick();
    d_s_valid = 0;
    checks++;
    if ({d_m_valid, d_m_data, d_m_keep, d_m_last} !== {1'b1, b, 32'hFFFF_FFFF, 1'b1}) begin
      errors++; $display("FAIL down_tail_seg0: v=%b d=%h k=%h l=%b want v=1 d=%h k=ffffffff l=1",
                         d_m_valid, d_m_data, d_m_keep, d_m_last, b);
    end
    tick();
    checks++;
    if (d_m_valid !== 1'b0) begin
      errors++; $display("FAIL down_tail_no_upper: got valid %b want 0", d_m_valid);
    end
    // tlast beat with no enabled bytes still yields one empty terminating segment
    d_s_valid = 1; d_s_keep = '0; d_s_last = 1;
    tick();
    d_s_valid = 0;
    checks++;
    if ({d_m_valid, d_m_keep, d_m_last} !== {1'b1, 32'h0, 1'b1}) begin
      errors++; $display("FAIL down_zero_keep: v=%b k=%h l=%b want v=1 k=0 l=1", d_m_valid, d_m_keep, d_m_last);
    end
    tick();
    checks++;
    if (d_m_valid !== 1'b0) begin
      errors++; $display("FAIL down_zero_keep_drain: got valid %b want 0", d_m_valid);
    end
  endtask

  task automatic test_up_three();
    logic [255:0] x, y, z;
    x = {8{32'h1111_0001}};
    y = {8{32'h2222_0002}};
    z = {8{32'h3333_0003}};
    u_m_ready = 1;
    u_s_valid = 1; u_s_keep = '1; u_s_id = 16'h0005; u_s_last = 0; u_s_data = x;
    tick();
    checks++;
    if (u_m_valid !== 1'b0) begin
      errors++; $display("FAIL up_half_beat: got valid %b want 0", u_m_valid);
    end
    u_s_data = y;
    tick();
    checks++;
    if ({u_m_valid, u_m_data, u_m_keep, u_m_last, u_m_id} !== {1'b1, y, x, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 16'h0005}) begin
      errors++; $display("FAIL up_beat1: v=%b d=%h k=%h l=%b id=%h", u_m_valid, u_m_data, u_m_keep, u_m_last, u_m_id);
    end
    u_s_data = z; u_s_last = 1;
    tick();
    u_s_valid = 0; u_s_last = 0;
    checks++;
    if ({u_m_valid, u_m_data, u_m_keep, u_m_last, u_m_id} !== {1'b1, 256'h0, z, 64'h0000_0000_FFFF_FFFF, 1'b1, 16'h0005}) begin
      errors++; $display("FAIL up_beat2: v=%b d=%h k=%h l=%b id=%h", u_m_valid, u_m_data, u_m_keep, u_m_last, u_m_id);
    end
    tick();
    checks++;
    if (u_m_valid !== 1'b0) begin
      errors++; $display("FAIL up_drain: got valid %b want 0", u_m_valid);
    end
  endtask

  task automatic run_down(input bit rnd);
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    bit prev_stall = 0;
    logic [255:0] prev_data = '0;
    while (got < 128 && cyc < 3000) begin
      d_s_valid = (sent < 64);
      d_s_data  = {w(2 * sent + 1), w(2 * sent)};
      d_s_keep  = '1;
      d_s_last  = (sent == 63);
      d_m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (prev_stall) begin
        checks++;
        if ({d_m_valid, d_m_data} !== {1'b1, prev_data}) begin
          errors++; $display("FAIL down_stall_hold: v=%b d=%h want v=1 d=%h", d_m_valid, d_m_data, prev_data);
        end
      end
      if (d_m_valid && d_m_ready) begin
        checks++;
        if ({d_m_data, d_m_last} !== {w(got), got == 127}) begin
          errors++; $display("FAIL down_stream[%0d]: d=%h l=%b want d=%h l=%b", got, d_m_data, d_m_last, w(got), got == 127);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      prev_stall = d_m_valid && !d_m_ready;
      prev_data  = d_m_data;
      if (d_s_valid && d_s_ready) sent++;
      tick();
      cyc++;
    end
    d_s_valid = 0; d_s_last = 0; d_m_ready = 1;
    checks++;
    if (got != 128) begin
      errors++; $display("FAIL down_stream_count: got %0d beats want 128", got);
    end
    if (!rnd) begin
      checks++;
      if (last - first + 1 != 128) begin
        errors++; $display("FAIL down_full_rate: span %0d cycles want 128", last - first + 1);
      end
    end
    repeat (2) tick();
  endtask

  task automatic run_up(input bit rnd);
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    bit prev_stall = 0;
    logic [511:0] prev_data = '0;
    while (got < 32 && cyc < 3000) begin
      u_s_valid = (sent < 64);
      u_s_data  = w(sent);
      u_s_keep  = '1;
      u_s_id    = 16'h0009;
      u_s_last  = (sent == 63);
      u_m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (prev_stall) begin
        checks++;
        if ({u_m_valid, u_m_data} !== {1'b1, prev_data}) begin
          errors++; $display("FAIL up_stall_hold: v=%b d=%h want v=1 d=%h", u_m_valid, u_m_data, prev_data);
        end
      end
      if (u_m_valid && u_m_ready) begin
        checks++;
        if ({u_m_data, u_m_keep, u_m_last} !== {w(2 * got + 1), w(2 * got), 64'hFFFF_FFFF_FFFF_FFFF, got == 31}) begin
          errors++; $display("FAIL up_stream[%0d]: d=%h k=%h l=%b", got, u_m_data, u_m_keep, u_m_last);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      prev_stall = u_m_valid && !u_m_ready;
      prev_data  = u_m_data;
      if (u_s_valid && u_s_ready) sent++;
      tick();
      cyc++;
    end
    u_s_valid = 0; u_s_last = 0; u_m_ready = 1;
    checks++;
    if (got != 32) begin
      errors++; $display("FAIL up_stream_count: got %0d beats want 32", got);
    end
    if (!rnd) begin
      // one wide beat every second cycle: 32 beats span 63 cycles
      checks++;
      if (last - first + 1 != 63) begin
        errors++; $display("FAIL up_full_rate: span %0d cycles want 63", last - first + 1);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    run_down(1'b0);
    run_up(1'b0);
    run_down(1'b1);
    run_up(1'b1);
  endtask

  task automatic test_reset_mid();
    logic [255:0] a, b, c;
    a = {8{32'h0A0A_0001}};
    b = {8{32'h0B0B_0002}};
    c = {8{32'h0C0C_0003}};
    d_m_ready = 1;
    d_s_valid = 1; d_s_data = {a, b}; d_s_keep = '1; d_s_last = 1;
    tick();
    d_s_valid = 0;
    tick();
    checks++;
    if ({d_m_valid, d_m_data} !== {1'b1, a}) begin
      errors++; $display("FAIL mid_seg1_before_reset: v=%b d=%h want v=1 d=%h", d_m_valid, d_m_data, a);
    end
    aresetn = 0;
    #1;
    checks++;
    if ({d_m_valid, d_s_ready, d_m_data} !== {1'b0, 1'b0, 256'h0}) begin
      errors++; $display("FAIL mid_reset_async: v=%b rdy=%b d=%h want 0 0 0", d_m_valid, d_s_ready, d_m_data);
    end
    tick();
    @(negedge aclk);
    aresetn = 1;
    tick();
    checks++;
    if (d_m_valid !== 1'b0) begin
      errors++; $display("FAIL mid_no_stale: got valid %b want 0", d_m_valid);
    end
    d_s_valid = 1; d_s_data = {a, c}; d_s_keep = 64'h0000_0000_FFFF_FFFF; d_s_last = 1;
    tick();
    d_s_valid = 0;
    checks++;
    if ({d_m_valid, d_m_data, d_m_last} !== {1'b1, c, 1'b1}) begin
      errors++; $display("FAIL mid_new_packet: v=%b d=%h l=%b want v=1 d=%h l=1", d_m_valid, d_m_data, d_m_last, c);
    end
    tick();
    checks++;
    if (d_m_valid !== 1'b0) begin
      errors++; $display("FAIL mid_new_drain: got valid %b want 0", d_m_valid);
    end
  endtask

  task automatic test_ratio_one();
    int sent = 0, got = 0, cyc = 0, first_in = -1, first_out = -1, last = -1;
    p_m_ready = 1;
    while (got < 20 && cyc < 200) begin
      p_s_valid = (sent < 20);
      p_s_data  = w(sent + 100);
      p_s_keep  = 32'(sent * 7 + 1);
      p_s_id    = 16'(sent);
      p_s_last  = (sent == 19);
      @(negedge aclk);
      if (p_m_valid) begin
        checks++;
        if ({p_m_data, p_m_keep, p_m_id, p_m_last} !== {w(got + 100), 32'(got * 7 + 1), 16'(got), got == 19}) begin
          errors++; $display("FAIL pass_beat[%0d]: d=%h k=%h id=%h l=%b", got, p_m_data, p_m_keep, p_m_id, p_m_last);
        end
        if (first_out < 0) first_out = cyc;
        last = cyc;
        got++;
      end
      if (p_s_valid && p_s_ready) begin
        if (first_in < 0) first_in = cyc;
        sent++;
      end
      tick();
      cyc++;
    end
    p_s_valid = 0; p_s_last = 0;
    checks++;
    if (got != 20) begin
      errors++; $display("FAIL pass_count: got %0d want 20", got);
    end
    checks++;
    if (first_out - first_in != 1 || last - first_out + 1 != 20) begin
      errors++; $display("FAIL pass_timing: latency %0d span %0d want 1 and 20", first_out - first_in, last - first_out + 1);
    end
  endtask

  initial begin
    test_reset();
    test_down_full();
    test_down_tail();
    test_up_three();
    test_back_to_back();
    test_reset_mid();
    test_ratio_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1);
  end

endmodule

// File: doc/axis_dwidth_conv_n.md
Name: axis_dwidth_conv_n

Overview:
- Parametrised AXI4-Stream data-width converter (tdata/tkeep/tid/tlast). Covers both downsize and upsize with one module, selected at elaboration.
- Replaces the fixed 512->256 and 256->512 converters that sit between the user stream interfaces and a narrow-datapath accelerator core.
- Adds tkeep-aware packet tails over the fixed converters:
  - Downsize drops trailing empty segments of a final beat.
  - Upsize flushes a partial wide beat on tlast, zero-keeping the missing lanes.

Parameters:
- S_DATA_BITS, 512, slave (input) tdata width; multiple of 8.
- M_DATA_BITS, 256, master (output) tdata width; multiple of 8.
- ID_BITS, 16, tid width, carried unchanged.
- Elaboration check: max/min of the two widths must be a power of two (1, 2, 4, 8). RATIO = that quotient. Equal widths give a one-stage register slice.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input accept
- s_axis_tdata  in  S_DATA_BITS  input data, lane 0 = bits [7:0]
- s_axis_tkeep  in  S_DATA_BITS/8  input byte enables
- s_axis_tid  in  ID_BITS  input stream id
- s_axis_tlast  in  1  end of packet
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  output accept
- m_axis_tdata  out  M_DATA_BITS  output data
- m_axis_tkeep  out  M_DATA_BITS/8  output byte enables
- m_axis_tid  out  ID_BITS  output stream id
- m_axis_tlast  out  1  end of packet

Behaviour:
- Reset (aresetn low, asynchronous):
  - m_axis_tvalid=0, s_axis_tready=0 while asserted; s_axis_tready=1 from the first clock after deassertion.
  - m_axis_tdata/tkeep/tid/tlast reset to 0.
  - Counters reset to 0.
  - Reset mid-packet discards all buffered data; no partial beat is emitted afterwards.
- All outputs are registered. No combinational path from s_axis_* to m_axis_*.
- The only combinational input-to-output path allowed is m_axis_tready -> s_axis_tready.
- AXI rules:
  - Transfer when valid && ready.
  - m_axis_tvalid, once high, holds with stable payload until accepted.
  - tid is constant within a packet; interleaving is not supported and is not checked.
- Downsize (S > M): state IDLE/EMIT, segment counter seg (log2 RATIO bits).
  - IDLE: s_axis_tready=1; on accept latch the wide beat, seg=0 -> EMIT. m_axis_tvalid rises on the next cycle (latency 1).
  - EMIT: output segment seg (data/keep slice seg*M_DATA_BITS), tid, tlast.
  - Segment last := (seg==RATIO-1) || (beat tlast && keep of all segments above seg == 0).
  - m_axis_tlast = beat tlast && segment last.
  - On accept of the last segment: s_axis_tready is 1 in that same cycle. A new beat accepted back-to-back gives zero bubbles (full rate). Otherwise -> IDLE.
  - Non-tlast beats always emit all RATIO segments, including all-zero-keep ones.
  - A tlast beat with all-zero tkeep still emits segment 0 with keep=0, tlast=1.
- Upsize (M > S): accumulator plus counter idx, output register.
  - Accept narrow beat into lane idx; tid taken from idx==0 beat.
  - Emit when idx==RATIO-1 or tlast:
    - lanes not written get keep=0, data=0;
    - m_axis_tlast = input tlast;
    - idx -> 0.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready || (not emitting this beat). Full rate sustained.
  - Latency: 1 cycle after the completing narrow beat.
- RATIO==1: single register slice with 1-cycle latency and full throughput.
- Simultaneous accept in and out in the same cycle is always legal. Counters never wrap except by the rules above.

Decomposition:
- Shared package (lynxTypes): no new typedefs. Add a function clog2_ratio and constant AXIS_DWIDTH_MAX_RATIO=8.
- Sub-module axis_dwidth_slice: a one-beat tdata/tkeep/tid/tlast output register with valid/ready. Used by all three modes as the output stage.

Test Plan:
- Down 512->256, one beat, keep all-ones, tlast=1, data=A||B -> two beats: B (keep 0xFFFFFFFF, tlast 0), then A (tlast 1). Valid rises 1 cycle after accept.
- Down 512->256, tlast beat with keep=0x00000000_FFFFFFFF -> single beat, low half, tlast=1. Upper segment not emitted.
- Up 256->512, three beats X, Y, Z, tlast on Z, tid=0x5 -> beat 1: Y||X, keep all-ones. Beat 2: 0||Z, keep=0x00000000_FFFFFFFF, tlast 1, tid 0x5.
- Back-to-back 64-beat packet in both modes, m_axis_tready=1 -> output beat count 32/128 with no idle cycles. Random m_axis_tready at 50% -> data identical, payload stable while stalled.
- aresetn pulled low mid-packet (downsize, after first segment) -> m_axis_tvalid=0 immediately. After release, a new packet emits cleanly with no stale segment.
- RATIO==1 (256->256) -> output equals input delayed 1 cycle, full throughput.
